// File: rtl/instr_prefetch_unit.sv
// Purpose: sequential instruction prefetcher buffering {address, instruction} pairs in a DEPTH-entry FIFO.
// Latency: a redirect at edge N puts the target on mem_addr_o in cycle N+1 and, with memory ready, on the head in N+2.
// Backpressure: instr_ready_i low lets the FIFO fill; at DEPTH entries mem_rd_o drops until the ID stage pops.
//
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   mem_rd_o, mem_addr_o               fetch request and address to instruction memory
//   mem_ready_i, mem_data_i            memory handshake; data valid in the same cycle as ready
//   redirect_i, redirect_addr_i        taken jump/branch from MEM: flush and restart at the target
//   instr_valid_o, instr_ready_i       head-entry handshake with the ID stage
//   instr_o, instr_addr_o              head instruction and its address (zero when empty)
//   fifo_count_o                       occupied entries
//   misalign_o                         sticky flag: a redirect target had non-zero low bits
module instr_prefetch_unit #(
    parameter int                 XLEN       = 32,
    parameter int                 DEPTH      = 4,
    parameter logic [XLEN-1:0]    RESET_ADDR = '0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        mem_ready_i,
    input  logic [XLEN-1:0]             mem_data_i,
    output logic [XLEN-1:0]             mem_addr_o,
    output logic                        mem_rd_o,
    input  logic                        redirect_i,
    input  logic [XLEN-1:0]             redirect_addr_i,
    input  logic                        instr_ready_i,
    output logic                        instr_valid_o,
    output logic [XLEN-1:0]             instr_o,
    output logic [XLEN-1:0]             instr_addr_o,
    output logic [$clog2(DEPTH+1)-1:0]  fifo_count_o,
    output logic                        misalign_o
);

    localparam int              CW      = $clog2(DEPTH + 1);
    localparam int              PW      = $clog2(DEPTH);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] instr;
    } entry_t;

    entry_t             entries [DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [CW-1:0]      count;
    logic [XLEN-1:0]    fetch_pc;
    logic               misalign;

    logic               push;
    logic               pop;

    // Request depends only on registered occupancy (and reset), never on instr_ready_i,
    // so a full FIFO cannot accept a fetch even in a cycle where the head is popped.
    assign mem_rd_o      = !rst_i && (count < DEPTH_C);
    assign mem_addr_o    = fetch_pc;
    assign instr_valid_o = (count != '0);

    // Redirect squashes both the memory response and the ID-stage pop of that cycle.
    assign push = mem_rd_o && mem_ready_i && !redirect_i;
    assign pop  = instr_valid_o && instr_ready_i && !redirect_i;

    assign instr_o       = instr_valid_o ? entries[rd_ptr].instr : '0;
    assign instr_addr_o  = instr_valid_o ? entries[rd_ptr].addr  : '0;
    assign fifo_count_o  = count;
    assign misalign_o    = misalign;

    // Control state: pointers, occupancy, fetch PC and sticky misalign flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fetch_pc <= RESET_ADDR;
            misalign <= 1'b0;
        end else if (redirect_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fetch_pc <= {redirect_addr_i[XLEN-1:2], 2'b00};
            if (redirect_addr_i[1:0] != 2'b00) begin
                misalign <= 1'b1;
            end
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PW'(1);
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: count gates every read of it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            entries[wr_ptr] <= '{addr: fetch_pc, instr: mem_data_i};
        end
    end

endmodule
